// File: rtl/transmision_dac_if.sv
// Parallel-load / serial-out bundle for the 16-bit converter frame.
// master drives the request side, slave is the transmitter.
interface transmision_dac_if;
  logic        tx_start;
  logic [11:0] data_In;
  logic        SCLK;
  logic        CS;
  logic        SDATA;
  logic        busy;
  logic        tx_done_tick;

  modport master (
    output tx_start, data_In,
    input  SCLK, CS, SDATA, busy, tx_done_tick
  );

  modport slave (
    input  tx_start, data_In,
    output SCLK, CS, SDATA, busy, tx_done_tick
  );
endinterface

// File: rtl/transmision_dac.sv
// Serial DAC transmitter: 16-bit frame {2'b00, PD, data} on SCLK/CS/SDATA.
// SCLK divided from clk; SDATA updates on SCLK rise, DAC samples on fall.
module transmision_dac #(
  parameter int         DIV     = 50,
  parameter logic [1:0] PD_MODE = 2'b00
) (
  input  logic              clk,
  input  logic              reset,
  transmision_dac_if.slave  bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, QUIET} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [4:0]    r_bits, w_bits;
  logic [15:0]   r_sr, w_sr;
  logic          r_sclk, w_sclk;
  logic          r_cs, w_cs;
  logic          r_sdata, w_sdata;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          r_qhalf, w_qhalf;
  logic          w_tick;
  logic [15:0]   w_frame;

  assign w_frame = {2'b00, PD_MODE, bus.data_In};
  assign w_tick  = (r_cnt == CMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_sr    <= '0;
      r_sclk  <= 1'b1;
      r_cs    <= 1'b1;
      r_sdata <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_qhalf <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bits  <= w_bits;
      r_sr    <= w_sr;
      r_sclk  <= w_sclk;
      r_cs    <= w_cs;
      r_sdata <= w_sdata;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_qhalf <= w_qhalf;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bits  = r_bits;
    w_sr    = r_sr;
    w_sclk  = r_sclk;
    w_cs    = r_cs;
    w_sdata = r_sdata;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_qhalf = r_qhalf;
    unique case (r_state)
      IDLE: begin
        w_cnt  = '0;
        w_bits = '0;
        if (bus.tx_start) begin
          w_sdata = w_frame[15];
          w_sr    = {w_frame[14:0], 1'b0};
          w_cs    = 1'b0;
          w_busy  = 1'b1;
          w_state = SHIFT;
        end
      end
      SHIFT: begin
        if (!w_tick) begin
          w_cnt = r_cnt + 1'b1;
        end else begin
          w_cnt  = '0;
          w_sclk = ~r_sclk;
          if (r_sclk) begin
            w_bits = r_bits + 1'b1;
          end else if (r_bits == 5'd16) begin
            w_cs    = 1'b1;
            w_sdata = 1'b0;
            w_done  = 1'b1;
            w_qhalf = 1'b0;
            w_state = QUIET;
          end else begin
            w_sdata = r_sr[15];
            w_sr    = {r_sr[14:0], 1'b0};
          end
        end
      end
      QUIET: begin
        // two divider periods of CS high before the next frame
        if (!w_tick) begin
          w_cnt = r_cnt + 1'b1;
        end else begin
          w_cnt = '0;
          if (r_qhalf) begin
            w_busy  = 1'b0;
            w_bits  = '0;
            w_state = IDLE;
          end else begin
            w_qhalf = 1'b1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign bus.SCLK         = r_sclk;
  assign bus.CS           = r_cs;
  assign bus.SDATA        = r_sdata;
  assign bus.busy         = r_busy;
  assign bus.tx_done_tick = r_done;

endmodule

// File: tb/tb_transmision_dac.sv
// Scoreboard bench for transmision_dac: frames, timing, reset abort.
// Three instances cover DIV=2, PD_MODE=11 and DIV=5.
module tb_transmision_dac;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] f;
  } exp_t;

  logic clk;
  logic reset;
  logic [2:0]  st;
  logic [11:0] din0, din1, din2;
  logic [2:0]  sclk, cs, sd, bsy, dn;
  logic [2:0]  psclk, pcs, psd, pbsy;

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  exp_t q[$];

  int          divs[3] = '{2, 2, 5};
  int          n_done[3];
  int          done_cyc[3];
  int          done_prev[3];
  int          busy_fall[3];
  int          last_tog[3];
  int          cs_rise[3];
  logic        cs_rv[3];
  int          nfall[3];
  logic [15:0] shr[3];

  transmision_dac_if u_if0 ();
  transmision_dac_if u_if1 ();
  transmision_dac_if u_if2 ();

  transmision_dac #(.DIV(2), .PD_MODE(2'b00)) u_dut0 (
    .clk(clk), .reset(reset), .bus(u_if0.slave));
  transmision_dac #(.DIV(2), .PD_MODE(2'b11)) u_dut1 (
    .clk(clk), .reset(reset), .bus(u_if1.slave));
  transmision_dac #(.DIV(5), .PD_MODE(2'b00)) u_dut2 (
    .clk(clk), .reset(reset), .bus(u_if2.slave));

  assign u_if0.tx_start = st[0];
  assign u_if1.tx_start = st[1];
  assign u_if2.tx_start = st[2];
  assign u_if0.data_In  = din0;
  assign u_if1.data_In  = din1;
  assign u_if2.data_In  = din2;
  assign sclk = {u_if2.SCLK, u_if1.SCLK, u_if0.SCLK};
  assign cs   = {u_if2.CS, u_if1.CS, u_if0.CS};
  assign sd   = {u_if2.SDATA, u_if1.SDATA, u_if0.SDATA};
  assign bsy  = {u_if2.busy, u_if1.busy, u_if0.busy};
  assign dn   = {u_if2.tx_done_tick, u_if1.tx_done_tick,
                 u_if0.tx_done_tick};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag,
                          input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      n_done[i] = 0; done_cyc[i] = 0; done_prev[i] = 0;
      busy_fall[i] = 0; last_tog[i] = 0; cs_rise[i] = 0;
      cs_rv[i] = 1'b0; nfall[i] = 0; shr[i] = '0;
    end
    psclk = '1; pcs = '1; psd = '0; pbsy = '0;
  end

  // monitor: sample serial lines mid-cycle, pop scoreboard on done
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        nfall[i] = 0;
        cs_rv[i] = 1'b0;
      end else begin
        if (psclk[i] && !sclk[i] && !cs[i]) begin
          shr[i] = {shr[i][14:0], sd[i]};
          nfall[i]++;
        end
        if (sd[i] != psd[i] && !(pcs[i] && !cs[i]))
          check_eq("sdata_on_rise", {31'd0, sclk[i] && !psclk[i]}, 1);
        if (pcs[i] && !cs[i]) begin
          last_tog[i] = cyc;
          if (cs_rv[i])
            check_eq("cs_gap", {31'd0, (cyc - cs_rise[i]) >= 4}, 1);
        end else if (sclk[i] != psclk[i]) begin
          check_eq("half_period", cyc - last_tog[i], divs[i]);
          last_tog[i] = cyc;
        end
        if (!pcs[i] && cs[i]) begin
          cs_rise[i] = cyc;
          cs_rv[i]   = 1'b1;
        end
        if (pbsy[i] && !bsy[i]) busy_fall[i] = cyc;
        if (dn[i]) begin
          n_done[i]++;
          done_prev[i] = done_cyc[i];
          done_cyc[i]  = cyc;
          check_eq("q_nonempty", {31'd0, q.size() != 0}, 1);
          if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check_eq("frame_dut", {30'd0, e.id}, i);
            check_eq("frame", {16'd0, shr[i]}, {16'd0, e.f});
            check_eq("n_fall", nfall[i], 16);
          end
          nfall[i] = 0;
        end
      end
    end
    psclk = sclk; pcs = cs; psd = sd; pbsy = bsy;
  end

  task automatic send(input int i, input logic [11:0] d,
                      input logic [15:0] f, output int t0);
    @(negedge clk); #1;
    case (i)
      0: din0 = d;
      1: din1 = d;
      default: din2 = d;
    endcase
    st[i] = 1'b1;
    t0 = cyc;
    q.push_back({i[1:0], f});
    @(negedge clk); #1;
    st[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int n);
    int k;
    k = 0;
    while (n_done[i] < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_eq("done_wait", {31'd0, n_done[i] >= n}, 1);
    k = 0;
    while (bsy[i] && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_eq("idle_wait", {31'd0, bsy[i]}, 0);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_sclk"}, {31'd0, sclk[0]}, 1);
    check_eq({tag, "_cs"},   {31'd0, cs[0]}, 1);
    check_eq({tag, "_sdata"}, {31'd0, sd[0]}, 0);
    check_eq({tag, "_busy"}, {31'd0, bsy[0]}, 0);
    check_eq({tag, "_done"}, {31'd0, dn[0]}, 0);
  endtask

  initial begin
    int t0;
    int nd;
    exp_t junk;
    reset = 1'b0;
    st = '0;
    din0 = '0; din1 = '0; din2 = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("rst");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle("idle");

    // basic frame and timing
    send(0, 12'hA5C, 16'h0A5C, t0);
    wait_done(0, 1);
    check_eq("done_cycle", done_cyc[0] - t0, 65);
    check_eq("busy_fall", busy_fall[0] - t0, 69);
    check_eq("done_count1", n_done[0], 1);

    // start during a frame is ignored
    send(0, 12'hA5C, 16'h0A5C, t0);
    wait_cyc(t0 + 20);
    din0 = 12'hFFF; st[0] = 1'b1;
    @(negedge clk); #1;
    st[0] = 1'b0;
    wait_done(0, 2);
    repeat (100) @(negedge clk);
    #1;
    check_eq("no_queued_frame", n_done[0], 2);

    // held start: back-to-back frames
    @(negedge clk); #1;
    din0 = 12'h001; st[0] = 1'b1; t0 = cyc;
    q.push_back({2'd0, 16'h0001});
    q.push_back({2'd0, 16'h0800});
    wait_cyc(t0 + 30);
    din0 = 12'h800;
    wait_cyc(t0 + 70);
    st[0] = 1'b0;
    wait_done(0, 4);
    check_eq("b2b_period", done_cyc[0] - done_prev[0], 69);
    repeat (100) @(negedge clk);
    #1;
    check_eq("b2b_count", n_done[0], 4);

    // reset at the 8th falling edge
    send(0, 12'h5A5, 16'h05A5, t0);
    wait_cyc(t0 + 31);
    check_eq("pre_rst_sclk", {31'd0, sclk[0]}, 0);
    nd = n_done[0];
    reset = 1'b0;
    #1;
    check_idle("async_rst");
    junk = q.pop_back();
    repeat (5) @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check_eq("rst_no_done", n_done[0], nd);
    send(0, 12'h3C3, 16'h03C3, t0);
    wait_done(0, nd + 1);
    check_eq("post_rst_done", done_cyc[0] - t0, 65);

    // power-down bits
    send(1, 12'h000, 16'h3000, t0);
    wait_done(1, 1);

    // DIV=5
    send(2, 12'hFFF, 16'h0FFF, t0);
    wait_done(2, 1);
    check_eq("div5_done", done_cyc[2] - t0, 161);
    check_eq("div5_busy", busy_fall[2] - t0, 171);

    check_eq("q_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/transmision_dac.md
# transmision_dac

Serial transmitter for the 12-bit converter interface: it takes a 12-bit parallel word and shifts it out as a 16-bit frame on SCLK/CS/SDATA. Each frame is 2 don't-care bits, 2 power-down bits, then 12 data bits, MSB first. It is the transmit end of the same frame format that `Recepcion_Version2` receives, and it drives the DAC directly from the system clock domain. It generates SCLK internally by division and signals completion with a one-cycle tick.

## Interface
- `DIV`, default 50: SCLK half-period in `clk` cycles; minimum 2. With 100 MHz `clk`, the default gives 1 MHz SCLK.
- `PD_MODE`, default 2'b00: power-down bits placed at frame bits 13:12.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_start`  in  1  request to send; sampled only when `busy`=0.
- `data_In`  in  12  word to transmit; captured in the accept cycle.
- `SCLK`  out  1  serial clock; idles high.
- `CS`  out  1  frame select, active low.
- `SDATA`  out  1  serial data, MSB first.
- `busy`  out  1  high from the cycle after accept until the quiet period ends.
- `tx_done_tick`  out  1  one-cycle pulse marking the end of a frame.

## Operation
- States: IDLE, SHIFT, QUIET. `reset` forces IDLE asynchronously.
- Reset and IDLE output values: SCLK=1, CS=1, SDATA=0, busy=0, tx_done_tick=0. The divider and bit counter are cleared.
- Accept: in IDLE, `tx_start`=1 loads the shift register with {2'b00, PD_MODE, data_In}, then moves to SHIFT.
- `tx_start` in SHIFT or QUIET is ignored and is not queued.
- SHIFT: a divider counter (width $clog2(DIV)) toggles SCLK every DIV cycles.
  - SDATA changes only in the cycle SCLK rises.
  - SDATA is stable across every SCLK falling edge, which is where the DAC samples.
  - A 5-bit counter counts the 16 falling edges.
- After the 16th falling edge, SCLK rises again. In that same cycle: CS=1, SDATA=0, tx_done_tick=1. State goes to QUIET.
- QUIET: CS and SCLK held high for 2·DIV cycles, then busy=0 and state returns to IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
Cycle 0 is the cycle in which `tx_start` is sampled high in IDLE.
- Cycle 1: CS=0, busy=1, SCLK=1, SDATA=frame bit 15.
- Falling edge k (k=1..16) occurs at cycle 1+(2k−1)·DIV.
- Rising edge k occurs at cycle 1+2k·DIV. For k=1..15 it presents frame bit 15−k on SDATA.
- Rising edge 16, at cycle 1+32·DIV: CS=1, tx_done_tick=1, for exactly one cycle.
- busy falls at cycle 1+34·DIV. A new start is accepted in that cycle or later, so CS high time between frames is at least 2·DIV cycles.
- A `tx_start` held continuously high yields back-to-back frames at a period of 1+34·DIV cycles, each capturing `data_In` at its own accept cycle.
- Reset mid-frame:
  - Outputs return to idle values immediately, without waiting for a clock.
  - No tx_done_tick is produced and the partial frame is discarded.
  - The first start after release sends a complete frame.

## Test plan
All scenarios use DIV=2 unless stated otherwise.
- Reset, then pulse tx_start with data_In=12'hA5C → bits sampled at the 16 falling edges equal 16'h0A5C; tx_done_tick at cycle 65 only; busy low at cycle 69.
- During the 12'hA5C frame, pulse tx_start with data_In=12'hFFF → frame still 16'h0A5C; no second frame follows.
- Hold tx_start=1 with data_In=12'h001, switching it to 12'h800 mid-frame → frames are 16'h0001 then 16'h0800; CS high for ≥4 cycles between them; two done ticks 69 cycles apart.
- Assert reset low at the 8th falling edge → SCLK=1, CS=1, SDATA=0, busy=0 immediately; no done tick; after release, start with 12'h3C3 → full frame 16'h03C3.
- PD_MODE=2'b11 with data_In=12'h000 → frame 16'h3000.
- DIV=5 with data_In=12'hFFF → frame 16'h0FFF; SCLK half-period is 5 cycles; SDATA never changes in a cycle other than an SCLK rise.
